// File: rtl/serial_to_parallel_receiver.sv
// Serial-to-parallel receiver: reassembles N-bit frames (MSB- or LSB-first) from one bit per
// clock and hands completed words to a consumer through a valid/ready holding register.
module serial_to_parallel_receiver #(
  parameter  int unsigned N  = 4,
  localparam int unsigned CW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic         i_serial,
  input  logic         direction,
  input  logic         i_ready,
  output logic [N-1:0] o_data,
  output logic         o_valid,
  output logic         o_busy,
  output logic         o_overrun
);

  typedef enum logic {
    StIdle,
    StReceive
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [N-1:0]   r_sr;
  logic [N-1:0]   w_sr_next;
  logic [CW-1:0]  r_count;
  logic [CW-1:0]  w_count_next;
  logic           r_dir;
  logic           w_dir_next;
  logic [N-1:0]   r_data;
  logic [N-1:0]   w_data_next;
  logic           r_valid;
  logic           w_valid_next;
  logic           r_overrun;
  logic           w_overrun_next;

  logic           w_dir_eff;
  logic [N-1:0]   w_sr_base;
  logic [N-1:0]   w_sr_shift;
  logic           w_complete;

  // A frame start uses the live direction and an empty shift register; otherwise the
  // direction latched at the start of the frame applies.
  always_comb begin
    w_dir_eff  = i_start ? direction : r_dir;
    w_sr_base  = i_start ? '0 : r_sr;
    w_sr_shift = w_dir_eff ? {i_serial, w_sr_base[N-1:1]} : {w_sr_base[N-2:0], i_serial};
    w_complete = (r_state == StReceive) && !i_start && (r_count == CW'(N - 1));
  end

  always_comb begin
    w_state_next = r_state;
    w_sr_next    = r_sr;
    w_count_next = r_count;
    w_dir_next   = r_dir;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_sr_next    = w_sr_shift;
          w_dir_next   = direction;
          w_count_next = CW'(1);
          w_state_next = StReceive;
        end
      end
      StReceive: begin
        w_sr_next = w_sr_shift;
        if (i_start) begin
          w_dir_next   = direction;
          w_count_next = CW'(1);
        end else if (w_complete) begin
          w_count_next = '0;
          w_state_next = StIdle;
        end else begin
          w_count_next = r_count + CW'(1);
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Holding register: a completed word is dropped only if the previous one is still
  // pending and not being consumed on this same edge.
  always_comb begin
    w_data_next    = r_data;
    w_valid_next   = r_valid;
    w_overrun_next = r_overrun;
    if (w_complete) begin
      if (!r_valid || i_ready) begin
        w_data_next  = w_sr_shift;
        w_valid_next = 1'b1;
      end else begin
        w_overrun_next = 1'b1;
      end
    end else if (r_valid && i_ready) begin
      w_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_sr      <= '0;
      r_count   <= '0;
      r_dir     <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_sr      <= w_sr_next;
      r_count   <= w_count_next;
      r_dir     <= w_dir_next;
      r_data    <= w_data_next;
      r_valid   <= w_valid_next;
      r_overrun <= w_overrun_next;
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_busy    = (r_state == StReceive);
  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_serial_to_parallel_receiver.sv
// Scoreboard bench for serial_to_parallel_receiver (N=4): stimulus pushes expected words,
// a monitor pops and compares each word the receiver presents.
module tb_serial_to_parallel_receiver;

  logic       clk;
  logic       rst;
  logic       i_start;
  logic       i_serial;
  logic       direction;
  logic       i_ready;
  logic [3:0] o_data;
  logic       o_valid;
  logic       o_busy;
  logic       o_overrun;

  int checks;
  int failures;
  logic [3:0] exp_q[$];

  serial_to_parallel_receiver #(.N(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_start  (i_start),
    .i_serial (i_serial),
    .direction(direction),
    .i_ready  (i_ready),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .o_busy   (o_busy),
    .o_overrun(o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Upstream parallel-to-serial stage: returns the bit order on the wire (index 3 first).
  function automatic logic [3:0] p2s_order(input logic [3:0] word, input logic lsb_first);
    logic [3:0] s;
    for (int i = 0; i < 4; i++) s[i] = lsb_first ? word[3-i] : word[i];
    return s;
  endfunction

  // seq[3] goes out first; rdy likewise per cycle. direction is flipped after the start
  // cycle so every frame also checks that only the latched direction is used.
  task automatic send(input logic [3:0] seq, input logic dir, input logic [3:0] rdy,
                      input logic busy0);
    for (int i = 3; i >= 0; i--) begin
      tick();
      i_start   = (i == 3);
      i_serial  = seq[i];
      direction = (i == 3) ? dir : ~dir;
      i_ready   = rdy[i];
      @(negedge clk);
      chk("busy_during_frame", o_busy, (i == 3) ? busy0 : 1'b1);
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) begin
      tick();
      i_start   = 1'b0;
      i_serial  = 1'b0;
      direction = 1'b0;
      i_ready   = rdy;
    end
    @(negedge clk);
  endtask

  // Monitor: a new word is presented when o_valid is high and the holding register was
  // empty or being consumed at the previous edge.
  initial begin
    logic prev_valid;
    logic prev_ready;
    logic [3:0] exp;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        if (o_valid && (!prev_valid || prev_ready)) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word: got %0h expected none", o_data);
          end else begin
            exp = exp_q.pop_front();
            chk("word_data", o_data, exp);
          end
        end
        prev_valid = o_valid;
      end
      prev_ready = i_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    i_start   = 1'b0;
    i_serial  = 1'b0;
    direction = 1'b0;
    i_ready   = 1'b0;
    repeat (3) tick();
    // Drive garbage during reset: reset must win.
    i_start = 1'b1; i_serial = 1'b1; i_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("reset_data", o_data, 4'h0);
    chk("reset_valid", o_valid, 1'b0);
    chk("reset_busy", o_busy, 1'b0);
    chk("reset_overrun", o_overrun, 1'b0);
    tick();
    rst = 1'b0; i_start = 1'b0; i_serial = 1'b0; i_ready = 1'b1;

    // 1: bits 1,0,1,1 MSB-first -> 1011
    exp_q.push_back(4'b1011);
    send(4'b1011, 1'b0, 4'b1111, 1'b0);
    idle(1, 1'b1);
    chk("t1_valid", o_valid, 1'b1);
    chk("t1_busy_after", o_busy, 1'b0);
    idle(2, 1'b1);

    // 2: same bits LSB-first -> 1101; upstream stage with 4'hA both directions
    exp_q.push_back(4'b1101);
    send(4'b1011, 1'b1, 4'b1111, 1'b0);
    exp_q.push_back(4'hA);
    send(p2s_order(4'hA, 1'b0), 1'b0, 4'b1111, 1'b0);
    exp_q.push_back(4'hA);
    send(p2s_order(4'hA, 1'b1), 1'b1, 4'b1111, 1'b0);
    idle(3, 1'b1);
    chk("t2_drained", o_valid, 1'b0);

    // 3: overrun with consumer stalled
    exp_q.push_back(4'hA);
    send(4'b1010, 1'b0, 4'b0000, 1'b0);
    send(4'b0101, 1'b0, 4'b0000, 1'b0);
    idle(1, 1'b0);
    chk("t3_data_kept", o_data, 4'hA);
    chk("t3_valid", o_valid, 1'b1);
    chk("t3_overrun", o_overrun, 1'b1);
    idle(1, 1'b1);
    idle(1, 1'b0);
    chk("t3_valid_cleared", o_valid, 1'b0);
    chk("t3_overrun_sticky", o_overrun, 1'b1);
    chk("t3_data_hold", o_data, 4'hA);

    // 4: consume and reload on the same edge
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.push_back(4'h3);
    send(4'b0011, 1'b0, 4'b0000, 1'b0);
    idle(1, 1'b0);
    chk("t4_hold3", o_data, 4'h3);
    exp_q.push_back(4'hC);
    send(4'b1100, 1'b0, 4'b0001, 1'b0);
    idle(1, 1'b0);
    chk("t4_data", o_data, 4'hC);
    chk("t4_valid", o_valid, 1'b1);
    chk("t4_overrun", o_overrun, 1'b0);
    idle(3, 1'b1);

    // 5a: restart after two bits -> only 0101
    tick();
    i_start = 1'b1; i_serial = 1'b1; direction = 1'b0; i_ready = 1'b1;
    tick();
    i_start = 1'b0; i_serial = 1'b1;
    @(negedge clk);
    chk("t5_busy_partial", o_busy, 1'b1);
    exp_q.push_back(4'b0101);
    send(4'b0101, 1'b0, 4'b1111, 1'b1);
    chk("t5_no_early_valid", o_valid, 1'b0);
    idle(1, 1'b1);
    chk("t5_valid_after_restart", o_valid, 1'b1);
    idle(2, 1'b1);

    // 5b: reset mid-frame, then a clean frame
    tick();
    i_start = 1'b1; i_serial = 1'b1;
    tick();
    i_start = 1'b0; i_serial = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_data", o_data, 4'h0);
    chk("t5_rst_valid", o_valid, 1'b0);
    chk("t5_rst_busy", o_busy, 1'b0);
    chk("t5_rst_overrun", o_overrun, 1'b0);
    exp_q.push_back(4'h9);
    send(4'b1001, 1'b0, 4'b1111, 1'b0);
    idle(3, 1'b1);

    // 6: LSB latched, direction flipped mid-frame (send flips it) -> bits 0,1,1,1 -> 1110
    exp_q.push_back(4'b1110);
    send(4'b0111, 1'b1, 4'b1111, 1'b0);
    idle(3, 1'b1);

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
